// File: rtl/seq_detect_prog_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_detect_prog_if                                        |
// | Purpose  : Serial data, configuration and status signals of the      |
// |            programmable sequence detector.                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface seq_detect_prog_if #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             armed;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic [LEN_W-1:0] fill;
  logic             cfg_err;

  // Stimulus side: drives data/config, observes status
  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  armed, match, match_count, fill, cfg_err
  );

  // Detector side
  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output armed, match, match_count, fill, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/seq_detect_prog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_detect_prog                                           |
// | Purpose  : Runtime-programmable serial pattern detector with         |
// |            overlap control and a saturating match counter.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module seq_detect_prog #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  seq_detect_prog_if.slave  bus
);

  typedef enum logic [0:0] {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             ovl_q, ovl_d;
  logic             match_q, match_d;
  logic             cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] w_mask;
  logic [PAT_W-1:0] w_hist_shift;
  logic [LEN_W-1:0] w_fill_inc;
  logic             w_cfg_ok;
  logic             w_hit;

  // Bit i takes part in the comparison only when it lies inside the active length
  for (genvar i = 0; i < PAT_W; i++) begin : g_mask
    assign w_mask[i] = (len_q > LEN_W'(i));
  end

  assign w_cfg_ok     = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(PAT_W));
  assign w_hist_shift = {hist_q[PAT_W-2:0], bus.in_bit};
  assign w_fill_inc   = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
  assign w_hit        = (w_fill_inc >= len_q) && (((w_hist_shift ^ pat_q) & w_mask) == '0);

  // Next-state: configuration load has priority over data; counter clear overrides increment
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    pat_d     = pat_q;
    len_d     = len_q;
    fill_d    = fill_q;
    ovl_d     = ovl_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;
    cnt_d     = cnt_q;

    if (bus.cfg_load) begin
      if (w_cfg_ok) begin
        pat_d   = bus.cfg_pattern;
        len_d   = bus.cfg_len;
        ovl_d   = bus.cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
        state_d = RUN;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (state_q == RUN && bus.in_valid) begin
      hist_d = w_hist_shift;
      fill_d = w_fill_inc;
      if (w_hit) begin
        match_d = 1'b1;
        if (!(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Non-overlap mode needs a full fresh pattern before the next match
        if (!ovl_q) begin
          fill_d = '0;
        end
      end
    end

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= UNCFG;
      hist_q    <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      ovl_q     <= 1'b0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      ovl_q     <= ovl_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.armed       = (state_q == RUN);
  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;
  assign bus.fill        = fill_q;
  assign bus.cfg_err     = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_seq_detect_prog                                        |
// | Purpose  : Scoreboard bench for seq_detect_prog with a bit-list      |
// |            reference model, directed scenarios and random traffic.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_seq_detect_prog;
  localparam int PAT_W = 4;
  localparam int LEN_W = 3;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    int id;
    bit armed;
    bit match;
    int count;
    int fill;
    bit cfg_err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  seq_detect_prog_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_detect_prog #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   step_id = 0;

  // Reference model: list of bits received since the last clear point
  bit   m_armed = 0;
  int   m_pat = 0;
  int   m_len = 0;
  bit   m_ovl = 0;
  int   m_cnt = 0;
  bit   m_bits[$];

  function automatic exp_t model_out(bit match, bit err);
    exp_t e;
    int n;
    n = m_bits.size();
    e.id      = step_id;
    e.armed   = m_armed;
    e.match   = match;
    e.count   = m_cnt;
    e.fill    = (n < m_len) ? n : m_len;
    e.cfg_err = err;
    return e;
  endfunction

  // One clock of stimulus; the expected post-edge outputs go into the scoreboard
  task automatic step(bit valid, bit b, bit load = 0, int pat = 0, int len = 0,
                      bit ovl = 0, bit clr = 0);
    bit hit;
    bit err;
    @(negedge clk);
    reset            = 1'b0;
    bus.in_valid     = valid;
    bus.in_bit       = b;
    bus.cfg_load     = load;
    bus.cfg_pattern  = PAT_W'(pat);
    bus.cfg_len      = LEN_W'(len);
    bus.cfg_overlap  = ovl;
    bus.cnt_clr      = clr;
    hit = 0;
    err = 0;
    if (load) begin
      if (len >= 1 && len <= PAT_W) begin
        m_pat = pat; m_len = len; m_ovl = ovl; m_armed = 1;
        m_bits.delete();
      end else begin
        err = 1;
      end
    end else if (m_armed && valid) begin
      m_bits.push_back(b);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        hit = 1;
        for (int k = 0; k < m_len; k++)
          if (m_bits[m_bits.size() - 1 - k] != ((m_pat >> k) & 1)) hit = 0;
      end
      if (hit) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_ovl) m_bits.delete();
      end
    end
    if (clr) m_cnt = 0;
    exp_q.push_back(model_out(hit, err));
    step_id++;
  endtask

  // Reset held through one clock edge; everything returns to idle
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 0; bus.cfg_load = 0; bus.cnt_clr = 0;
    m_armed = 0; m_pat = 0; m_len = 0; m_ovl = 0; m_cnt = 0;
    m_bits.delete();
    exp_q.push_back(model_out(0, 0));
    step_id++;
  endtask

  task automatic send_bits(int n, int bits, int ovl_gap_max = 0);
    for (int i = n - 1; i >= 0; i--) begin
      step(1, bit'((bits >> i) & 1));
      for (int g = 0; g < ovl_gap_max; g++) step(0, bit'($urandom_range(0, 1)));
    end
  endtask

  // Monitor: compares DUT outputs just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if (bus.armed !== e.armed || bus.match !== e.match ||
            bus.match_count !== CNT_W'(e.count) || bus.fill !== LEN_W'(e.fill) ||
            bus.cfg_err !== e.cfg_err) begin
          bad++;
          $display("FAIL outputs step=%0d got armed=%0b match=%0b count=%0d fill=%0d cfg_err=%0b want armed=%0b match=%0b count=%0d fill=%0d cfg_err=%0b",
                   e.id, bus.armed, bus.match, bus.match_count, bus.fill, bus.cfg_err,
                   e.armed, e.match, e.count, e.fill, e.cfg_err);
        end
      end
    end
  end

  initial begin
    int r;
    int wait_cnt;
    bus.in_valid = 0; bus.in_bit = 0; bus.cfg_load = 0; bus.cfg_pattern = '0;
    bus.cfg_len = '0; bus.cfg_overlap = 0; bus.cnt_clr = 0;

    // Reset state, and data ignored while unconfigured
    do_reset();
    send_bits(3, 3'b111);

    // Overlapping 11 on 1,1,1
    step(0, 0, 1, 2'b11, 2, 1);
    send_bits(3, 3'b111);
    // Non-overlapping 11 on 1,1,1,1
    step(0, 0, 1, 2'b11, 2, 0, 1);
    send_bits(4, 4'b1111);
    // 1011 with gaps between bits
    step(0, 0, 1, 4'b1011, 4, 1, 1);
    send_bits(7, 7'b1011011, 3);
    // Rejected lengths leave everything unchanged
    step(0, 0, 1, 4'b0110, 0, 0);
    step(0, 0, 1, 4'b0110, 5, 0);
    send_bits(4, 4'b1011);
    // Load with in_valid: bit discarded, no match on that cycle
    step(1, 1, 1, 1'b1, 1, 1);
    send_bits(2, 2'b11);
    // Saturation, then clear coincident with a match
    step(0, 0, 1, 2'b11, 2, 1, 1);
    send_bits(5, 5'b11111);
    step(1, 1, 0, 0, 0, 0, 1);
    // Reset mid-pattern discards partial match
    step(0, 0, 1, 4'b1011, 4, 1);
    send_bits(3, 3'b101);
    do_reset();
    send_bits(1, 1'b1);

    // Random traffic with occasional loads, bad loads, clears and resets
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if (r < 6)
        step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1,
             $urandom_range(0, 15), $urandom_range(0, 7), bit'($urandom_range(0, 1)),
             bit'(r == 0));
      else if (r == 6)
        do_reset();
      else
        step(bit'($urandom_range(0, 9) < 7), bit'($urandom_range(0, 1)), 0, 0, 0, 0,
             bit'(r > 196));
    end

    step(0, 0);
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
